// File: rtl/branch_res_handler_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : branch_res_handler_pkg                                   |
// | Description : Shared types for the branch resolution handler:          |
// |               resolution record, BTB/predictor update records, FSM     |
// |               state encoding and the redirect target helper.           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package branch_res_handler_pkg;

  localparam int unsigned c_XLEN     = 32;
  localparam int unsigned c_ILEN     = 32;
  // Widest supported global history; the update record carries this width.
  localparam int unsigned c_HLEN_MAX = 32;

  typedef struct packed {
    logic [c_XLEN-1:0] pc;
    logic [c_XLEN-1:0] target;
    logic              taken;
    logic              mispredict;
  } resolution_t;

  typedef struct packed {
    logic              valid;
    logic              del;
    logic [c_XLEN-1:0] pc;
    logic [c_XLEN-1:0] target;
  } btb_upd_t;

  typedef struct packed {
    logic                  valid;
    logic [c_XLEN-1:0]     pc;
    logic                  taken;
    logic [c_HLEN_MAX-1:0] ghr;
  } bpu_upd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_UPD   = 2'd1,
    S_REDIR = 2'd2
  } res_handler_state_t;

  // Correct fetch PC after a mispredict: the real target if taken, else fall-through.
  function automatic logic [c_XLEN-1:0] redirect_target(input resolution_t res);
    return res.taken ? res.target : res.pc + c_XLEN'(c_ILEN >> 3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_res_handler_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : branch_res_handler_if                                    |
// | Description : Bundle of the branch-unit input, BTB/predictor update,   |
// |               redirect and history signals of the resolution handler.  |
// |               slave = handler side, master = surrounding frontend.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface branch_res_handler_if
  import branch_res_handler_pkg::*;
#(
  parameter int unsigned HLEN = 8
) ();

  logic              flush_i;
  logic              bu_valid_i;
  logic              bu_ready_o;
  resolution_t       bu_res_i;
  logic              btb_upd_valid_o;
  logic              btb_upd_del_o;
  logic [c_XLEN-1:0] btb_upd_pc_o;
  logic [c_XLEN-1:0] btb_upd_target_o;
  logic              bpu_upd_valid_o;
  logic [c_XLEN-1:0] bpu_upd_pc_o;
  logic              bpu_upd_taken_o;
  logic [HLEN-1:0]   bpu_upd_ghr_o;
  logic              redirect_valid_o;
  logic              redirect_ready_i;
  logic [c_XLEN-1:0] redirect_pc_o;
  logic [HLEN-1:0]   ghr_o;

  modport slave (
    input  flush_i, bu_valid_i, bu_res_i, redirect_ready_i,
    output bu_ready_o, btb_upd_valid_o, btb_upd_del_o, btb_upd_pc_o,
           btb_upd_target_o, bpu_upd_valid_o, bpu_upd_pc_o, bpu_upd_taken_o,
           bpu_upd_ghr_o, redirect_valid_o, redirect_pc_o, ghr_o
  );

  modport master (
    output flush_i, bu_valid_i, bu_res_i, redirect_ready_i,
    input  bu_ready_o, btb_upd_valid_o, btb_upd_del_o, btb_upd_pc_o,
           btb_upd_target_o, bpu_upd_valid_o, bpu_upd_pc_o, bpu_upd_taken_o,
           bpu_upd_ghr_o, redirect_valid_o, redirect_pc_o, ghr_o
  );

endinterface
`default_nettype wire

// File: rtl/branch_res_handler_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : res_fifo                                                 |
// | Description : Circular FIFO with wrap-bit pointers. Besides the head   |
// |               it exposes the head/emptiness as they will be after the  |
// |               current edge, so the owner can register its outputs.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module res_fifo #(
  parameter type         DATA_T = logic,
  parameter int unsigned DEPTH  = 4
) (
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  logic  flush_i,
  input  logic  push_i,
  input  DATA_T data_i,
  input  logic  pop_i,
  output logic  full_o,
  output logic  empty_o,
  output DATA_T head_o,
  output logic  nxt_empty_o,
  output DATA_T nxt_head_o
);

  localparam int unsigned c_AW = $clog2(DEPTH);

  DATA_T           r_mem [DEPTH];
  logic [c_AW:0]   r_head;
  logic [c_AW:0]   r_tail;
  logic [c_AW:0]   w_cnt;
  logic [c_AW:0]   w_cnt_nxt;
  logic [c_AW-1:0] w_hidx1;
  logic            w_push;
  logic            w_pop;

  assign full_o    = (r_head[c_AW] != r_tail[c_AW]) && (r_head[c_AW-1:0] == r_tail[c_AW-1:0]);
  assign empty_o   = (r_head == r_tail);
  assign w_push    = push_i && !full_o && !flush_i;
  assign w_pop     = pop_i && !empty_o && !flush_i;
  assign w_cnt     = r_tail - r_head;
  assign w_cnt_nxt = w_cnt + (c_AW+1)'(w_push) - (c_AW+1)'(w_pop);
  assign w_hidx1   = r_head[c_AW-1:0] + c_AW'(1);
  assign head_o    = r_mem[r_head[c_AW-1:0]];
  assign nxt_empty_o = flush_i || (w_cnt_nxt == '0);

  // Post-edge head: next stored entry, or the entry being pushed when the FIFO drains to it.
  always_comb begin
    nxt_head_o = data_i;
    if (w_pop) begin
      if (w_cnt > (c_AW+1)'(1)) nxt_head_o = r_mem[w_hidx1];
    end else if (!empty_o) begin
      nxt_head_o = r_mem[r_head[c_AW-1:0]];
    end
  end

  // Storage array, written at the tail.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_tail[c_AW-1:0]] <= data_i;
  end

  // Head/tail pointers; a flush empties the FIFO and drops any same-cycle push.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (flush_i) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + (c_AW+1)'(1);
      if (w_pop)  r_head <= r_head + (c_AW+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_res_handler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : branch_res_handler                                       |
// | Description : Buffers branch resolutions and drains them in order,     |
// |               pulsing BTB/predictor updates, shifting the committed    |
// |               GHR and holding a redirect for mispredicts.              |
// |               Optional: LEN5_BPU_STATS_EN adds resolution counters.    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module branch_res_handler
  import branch_res_handler_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned HLEN  = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  branch_res_handler_if.slave bus
`ifdef LEN5_BPU_STATS_EN
  ,
  output logic [31:0] stat_resolved_o,
  output logic [31:0] stat_mispred_o
`endif
);

  res_handler_state_t r_state;
  btb_upd_t           r_btb;
  bpu_upd_t           r_bpu;
  logic [HLEN-1:0]    r_ghr;
  logic               r_redir_valid;
  logic [c_XLEN-1:0]  r_redir_pc;

  resolution_t        w_head;
  resolution_t        w_nxt_head;
  logic               w_full;
  logic               w_empty;
  logic               w_nxt_empty;
  logic               w_push;
  logic               w_pop;
  logic [HLEN-1:0]    w_ghr_shift;
  logic [HLEN-1:0]    w_ghr_nxt;
  btb_upd_t           w_btb_nxt;
  bpu_upd_t           w_bpu_nxt;
  logic               w_unused;

  res_fifo #(
    .DATA_T (resolution_t),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (bus.flush_i),
    .push_i      (w_push),
    .data_i      (bus.bu_res_i),
    .pop_i       (w_pop),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .head_o      (w_head),
    .nxt_empty_o (w_nxt_empty),
    .nxt_head_o  (w_nxt_head)
  );

  assign w_push      = bus.bu_valid_i && !w_full;
  assign w_ghr_shift = {r_ghr[HLEN-2:0], w_head.taken};
  // History seen by the next pulse already includes the branch retiring this cycle.
  assign w_ghr_nxt   = (r_state == S_UPD) ? w_ghr_shift : r_ghr;

  // Head leaves on a correct update or once its redirect is accepted.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      S_UPD:   w_pop = !w_empty && !w_head.mispredict;
      S_REDIR: w_pop = !w_empty && bus.redirect_ready_i;
      default: w_pop = 1'b0;
    endcase
  end

  // Update records for the entry that will sit at the head after this edge.
  always_comb begin
    w_btb_nxt        = '0;
    w_btb_nxt.valid  = w_nxt_head.taken || w_nxt_head.mispredict;
    w_btb_nxt.del    = !w_nxt_head.taken && w_nxt_head.mispredict;
    w_btb_nxt.pc     = w_nxt_head.pc;
    w_btb_nxt.target = w_nxt_head.target;
    w_bpu_nxt        = '0;
    w_bpu_nxt.valid  = 1'b1;
    w_bpu_nxt.pc     = w_nxt_head.pc;
    w_bpu_nxt.taken  = w_nxt_head.taken;
    w_bpu_nxt.ghr    = c_HLEN_MAX'(w_ghr_nxt);
  end

  // Drain FSM with registered pulses, GHR and redirect. A flush in S_UPD
  // still commits that branch's history since its update was already issued.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= S_IDLE;
      r_btb         <= '0;
      r_bpu         <= '0;
      r_ghr         <= '0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
    end else begin
      r_btb.valid <= 1'b0;
      r_btb.del   <= 1'b0;
      r_bpu.valid <= 1'b0;
      if (r_state == S_UPD) r_ghr <= w_ghr_shift;
      if (bus.flush_i) begin
        r_state       <= S_IDLE;
        r_redir_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!w_nxt_empty) begin
              r_state <= S_UPD;
              r_btb   <= w_btb_nxt;
              r_bpu   <= w_bpu_nxt;
            end
          end
          S_UPD: begin
            if (w_head.mispredict) begin
              r_state       <= S_REDIR;
              r_redir_valid <= 1'b1;
              r_redir_pc    <= redirect_target(w_head);
            end else if (!w_nxt_empty) begin
              r_state <= S_UPD;
              r_btb   <= w_btb_nxt;
              r_bpu   <= w_bpu_nxt;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_REDIR: begin
            if (bus.redirect_ready_i) begin
              r_redir_valid <= 1'b0;
              if (!w_nxt_empty) begin
                r_state <= S_UPD;
                r_btb   <= w_btb_nxt;
                r_bpu   <= w_bpu_nxt;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign w_unused             = ^r_bpu.ghr;
  assign bus.bu_ready_o       = !w_full;
  assign bus.btb_upd_valid_o  = r_btb.valid;
  assign bus.btb_upd_del_o    = r_btb.del;
  assign bus.btb_upd_pc_o     = r_btb.pc;
  assign bus.btb_upd_target_o = r_btb.target;
  assign bus.bpu_upd_valid_o  = r_bpu.valid;
  assign bus.bpu_upd_pc_o     = r_bpu.pc;
  assign bus.bpu_upd_taken_o  = r_bpu.taken;
  assign bus.bpu_upd_ghr_o    = r_bpu.ghr[HLEN-1:0];
  assign bus.redirect_valid_o = r_redir_valid;
  assign bus.redirect_pc_o    = r_redir_pc;
  assign bus.ghr_o            = r_ghr;

`ifdef LEN5_BPU_STATS_EN
  logic [31:0] r_stat_resolved;
  logic [31:0] r_stat_mispred;

  // Saturating resolution/mispredict counters; independent of flush.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stat_resolved <= '0;
      r_stat_mispred  <= '0;
    end else if (r_state == S_UPD) begin
      if (r_stat_resolved != '1) r_stat_resolved <= r_stat_resolved + 32'd1;
      if (w_head.mispredict && (r_stat_mispred != '1)) r_stat_mispred <= r_stat_mispred + 32'd1;
    end
  end

  assign stat_resolved_o = r_stat_resolved;
  assign stat_mispred_o  = r_stat_mispred;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_res_handler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_branch_res_handler                                    |
// | Description : Directed self-checking bench for branch_res_handler.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_branch_res_handler;
  import branch_res_handler_pkg::*;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;
  int   n_vec   = 0;
  int   n_err   = 0;

  // 10 ns clock.
  always #5 clk_i = ~clk_i;

  branch_res_handler_if #(.HLEN(8)) bus ();

`ifdef LEN5_BPU_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispred;
`endif

  branch_res_handler #(
    .DEPTH (4),
    .HLEN  (8)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
`ifdef LEN5_BPU_STATS_EN
    ,
    .stat_resolved_o (stat_resolved),
    .stat_mispred_o  (stat_mispred)
`endif
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic resolution_t mk(input logic [31:0] pc, input logic [31:0] tg,
                                     input logic tk, input logic mi);
    return '{pc: pc, target: tg, taken: tk, mispredict: mi};
  endfunction

  logic [7:0] alt_ghr [8];

  initial begin
    alt_ghr = '{8'hB4, 8'h69, 8'hD2, 8'hA5, 8'h4A, 8'h95, 8'h2A, 8'h55};
    bus.flush_i          = 1'b0;
    bus.bu_valid_i       = 1'b0;
    bus.bu_res_i         = '0;
    bus.redirect_ready_i = 1'b0;
    step();
    step();
    chk("rst_btb_valid", 64'(bus.btb_upd_valid_o), 64'h0);
    chk("rst_bpu_valid", 64'(bus.bpu_upd_valid_o), 64'h0);
    chk("rst_redir_valid", 64'(bus.redirect_valid_o), 64'h0);
    chk("rst_redir_pc", 64'(bus.redirect_pc_o), 64'h0);
    chk("rst_ghr", 64'(bus.ghr_o), 64'h0);
    chk("rst_bu_ready", 64'(bus.bu_ready_o), 64'h1);
    rst_n_i = 1'b1;
    step();

    // Correct taken resolution.
    bus.bu_valid_i = 1'b1;
    bus.bu_res_i   = mk(32'h100, 32'h200, 1'b1, 1'b0);
    step();
    bus.bu_valid_i = 1'b0;
    chk("t1_btb_valid", 64'(bus.btb_upd_valid_o), 64'h1);
    chk("t1_btb_del", 64'(bus.btb_upd_del_o), 64'h0);
    chk("t1_btb_pc", 64'(bus.btb_upd_pc_o), 64'h100);
    chk("t1_btb_target", 64'(bus.btb_upd_target_o), 64'h200);
    chk("t1_bpu_valid", 64'(bus.bpu_upd_valid_o), 64'h1);
    chk("t1_bpu_taken", 64'(bus.bpu_upd_taken_o), 64'h1);
    chk("t1_bpu_ghr", 64'(bus.bpu_upd_ghr_o), 64'h0);
    chk("t1_redir", 64'(bus.redirect_valid_o), 64'h0);
    step();
    chk("t1_pulse_end", 64'(bus.bpu_upd_valid_o), 64'h0);
    chk("t1_ghr", 64'(bus.ghr_o), 64'h1);
    chk("t1_redir2", 64'(bus.redirect_valid_o), 64'h0);

    // Not-taken mispredict: delete then redirect to fall-through.
    bus.bu_valid_i = 1'b1;
    bus.bu_res_i   = mk(32'h300, 32'hDEAD, 1'b0, 1'b1);
    step();
    bus.bu_valid_i = 1'b0;
    chk("t2_btb_valid", 64'(bus.btb_upd_valid_o), 64'h1);
    chk("t2_btb_del", 64'(bus.btb_upd_del_o), 64'h1);
    chk("t2_btb_pc", 64'(bus.btb_upd_pc_o), 64'h300);
    chk("t2_bpu_taken", 64'(bus.bpu_upd_taken_o), 64'h0);
    chk("t2_bpu_ghr", 64'(bus.bpu_upd_ghr_o), 64'h1);
    chk("t2_redir_early", 64'(bus.redirect_valid_o), 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_redir_valid", 64'(bus.redirect_valid_o), 64'h1);
      chk("t2_redir_pc", 64'(bus.redirect_pc_o), 64'h304);
      chk("t2_no_pulse", 64'(bus.bpu_upd_valid_o), 64'h0);
    end
    chk("t2_ghr", 64'(bus.ghr_o), 64'h2);
    bus.redirect_ready_i = 1'b1;
    step();
    bus.redirect_ready_i = 1'b0;
    chk("t2_redir_done", 64'(bus.redirect_valid_o), 64'h0);
    step();
    chk("t2_idle", 64'(bus.bpu_upd_valid_o), 64'h0);

    // Five back-to-back resolutions behind a stalled taken mispredict.
    bus.bu_valid_i = 1'b1;
    bus.bu_res_i   = mk(32'h400, 32'h480, 1'b1, 1'b1);
    step();
    chk("t3_a_btb_del", 64'(bus.btb_upd_del_o), 64'h0);
    chk("t3_a_btb_target", 64'(bus.btb_upd_target_o), 64'h480);
    chk("t3_a_bpu_ghr", 64'(bus.bpu_upd_ghr_o), 64'h2);
    bus.bu_res_i = mk(32'h500, 32'h540, 1'b1, 1'b0);
    step();
    chk("t3_redir_pc", 64'(bus.redirect_pc_o), 64'h480);
    chk("t3_ghr_a", 64'(bus.ghr_o), 64'h5);
    bus.bu_res_i = mk(32'h600, 32'h640, 1'b0, 1'b0);
    step();
    chk("t3_ready_3", 64'(bus.bu_ready_o), 64'h1);
    bus.bu_res_i = mk(32'h700, 32'h740, 1'b1, 1'b0);
    step();
    chk("t3_full", 64'(bus.bu_ready_o), 64'h0);
    bus.bu_res_i = mk(32'h800, 32'h840, 1'b0, 1'b0);
    step();
    chk("t3_full_hold", 64'(bus.bu_ready_o), 64'h0);
    chk("t3_redir_hold", 64'(bus.redirect_valid_o), 64'h1);
    bus.redirect_ready_i = 1'b1;
    step();
    bus.redirect_ready_i = 1'b0;
    chk("t3_redir_off", 64'(bus.redirect_valid_o), 64'h0);
    chk("t3_b_pc", 64'(bus.bpu_upd_pc_o), 64'h500);
    chk("t3_b_ghr", 64'(bus.bpu_upd_ghr_o), 64'h5);
    chk("t3_ready_again", 64'(bus.bu_ready_o), 64'h1);
    step();
    bus.bu_valid_i = 1'b0;
    chk("t3_c_pc", 64'(bus.bpu_upd_pc_o), 64'h600);
    chk("t3_c_ghr", 64'(bus.bpu_upd_ghr_o), 64'hB);
    chk("t3_c_btb_valid", 64'(bus.btb_upd_valid_o), 64'h0);
    step();
    chk("t3_d_pc", 64'(bus.bpu_upd_pc_o), 64'h700);
    chk("t3_d_ghr", 64'(bus.bpu_upd_ghr_o), 64'h16);
    chk("t3_d_btb_target", 64'(bus.btb_upd_target_o), 64'h740);
    step();
    chk("t3_e_pc", 64'(bus.bpu_upd_pc_o), 64'h800);
    chk("t3_e_ghr", 64'(bus.bpu_upd_ghr_o), 64'h2D);
    step();
    chk("t3_drained", 64'(bus.bpu_upd_valid_o), 64'h0);
    chk("t3_ghr", 64'(bus.ghr_o), 64'h5A);

    // Flush while redirecting with three entries queued behind the head.
    bus.bu_valid_i = 1'b1;
    bus.bu_res_i   = mk(32'h900, 32'h980, 1'b0, 1'b1);
    step();
    chk("t4_btb_del", 64'(bus.btb_upd_del_o), 64'h1);
    bus.bu_res_i = mk(32'hA00, 32'hA40, 1'b1, 1'b0);
    step();
    chk("t4_redir_pc", 64'(bus.redirect_pc_o), 64'h904);
    bus.bu_res_i = mk(32'hB00, 32'hB40, 1'b1, 1'b0);
    step();
    bus.bu_res_i = mk(32'hC00, 32'hC40, 1'b1, 1'b0);
    step();
    bus.bu_valid_i = 1'b0;
    chk("t4_full", 64'(bus.bu_ready_o), 64'h0);
    chk("t4_ghr_pre", 64'(bus.ghr_o), 64'hB4);
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    chk("t4_redir_off", 64'(bus.redirect_valid_o), 64'h0);
    chk("t4_empty", 64'(bus.bu_ready_o), 64'h1);
    chk("t4_ghr_kept", 64'(bus.ghr_o), 64'hB4);
    step();
    chk("t4_no_pulse", 64'(bus.bpu_upd_valid_o), 64'h0);

    // Push coinciding with flush is dropped.
    bus.bu_valid_i = 1'b1;
    bus.bu_res_i   = mk(32'hD00, 32'hD40, 1'b1, 1'b0);
    bus.flush_i    = 1'b1;
    step();
    bus.bu_valid_i = 1'b0;
    bus.flush_i    = 1'b0;
    chk("t4_drop1", 64'(bus.bpu_upd_valid_o), 64'h0);
    step();
    chk("t4_drop2", 64'(bus.bpu_upd_valid_o), 64'h0);
    chk("t4_drop_ghr", 64'(bus.ghr_o), 64'hB4);

    // Eight alternating correct resolutions, first taken.
    bus.bu_valid_i = 1'b1;
    bus.bu_res_i   = mk(32'h1000, 32'h1008, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t5_bpu_valid", 64'(bus.bpu_upd_valid_o), 64'h1);
      chk("t5_bpu_taken", 64'(bus.bpu_upd_taken_o), 64'((k % 2) == 0));
      chk("t5_bpu_ghr", 64'(bus.bpu_upd_ghr_o), 64'(alt_ghr[k]));
      if (k < 7) begin
        bus.bu_res_i = mk(32'h1000 + 32'(k + 1) * 32'h10, 32'h1008 + 32'(k + 1) * 32'h10,
                          ((k + 1) % 2) == 0, 1'b0);
      end else begin
        bus.bu_valid_i = 1'b0;
      end
    end
    step();
    chk("t5_ghr", 64'(bus.ghr_o), 64'hAA);
    chk("t5_idle", 64'(bus.bpu_upd_valid_o), 64'h0);

`ifdef LEN5_BPU_STATS_EN
    chk("stat_resolved", 64'(stat_resolved), 64'd16);
    chk("stat_mispred", 64'(stat_mispred), 64'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_res_handler.md
Name: branch_res_handler

Overview:
- Frontend-side receiver of branch resolutions produced by the execution-stage branch unit.
- Buffers resolutions (pc, target, taken, mispredict) in a small FIFO, then drains them in order.
- Per resolution: issues one-cycle update pulses to the BTB and the branch predictor counters, and shifts the committed global history register.
- On a mispredicted resolution: holds a PC redirect request to the PC generator until it is accepted.

Parameters:
- DEPTH, 4, resolution FIFO entries; power of 2, >= 2.
- HLEN, 8, global history register width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous pipeline flush
- bu_valid_i  in  1  resolution valid from branch unit
- bu_ready_o  out  1  FIFO can accept a resolution
- bu_res_i  in  2*XLEN+2  resolution_t {pc, target, taken, mispredict}
- btb_upd_valid_o  out  1  BTB write pulse
- btb_upd_del_o  out  1  1 = invalidate entry at btb_upd_pc_o; 0 = write target
- btb_upd_pc_o  out  XLEN  BTB index/tag source PC
- btb_upd_target_o  out  XLEN  target to write
- bpu_upd_valid_o  out  1  predictor counter update pulse
- bpu_upd_pc_o  out  XLEN  branch PC
- bpu_upd_taken_o  out  1  resolved direction
- bpu_upd_ghr_o  out  HLEN  GHR value before this branch is shifted in
- redirect_valid_o  out  1  redirect request to PC generator
- redirect_ready_i  in  1  PC generator accepts redirect
- redirect_pc_o  out  XLEN  corrected fetch PC
- ghr_o  out  HLEN  committed global history

Behaviour:
- Reset: all outputs 0, FIFO empty, state S_IDLE, GHR 0.
- FIFO:
  - Circular buffer of DEPTH entries, log2(DEPTH)+1-bit head/tail pointers (wrap bit distinguishes full from empty).
  - bu_ready_o = !full, combinational from pointers only; it does not depend on a same-cycle pop.
  - Push when bu_valid_i && bu_ready_o.
  - A pushed entry is first visible at the head on the next cycle.
- FSM states:
  - S_IDLE: FIFO empty. Go to S_UPD when not empty.
  - S_UPD: process head entry for exactly one cycle:
    - Assert bpu_upd_valid_o with head pc/taken and the current GHR.
    - btb_upd_valid_o = taken || mispredict.
    - btb_upd_del_o = !taken && mispredict; otherwise write head target.
    - GHR <= {GHR[HLEN-2:0], taken} on the same edge.
    - If !mispredict: pop head; next state S_UPD if FIFO still non-empty after the pop, else S_IDLE.
    - If mispredict: latch redirect_pc = taken ? target : pc + (ILEN>>3); do not pop; go to S_REDIR.
  - S_REDIR:
    - redirect_valid_o = 1; redirect_pc_o held stable; no update pulses.
    - On redirect_ready_i: pop head; next state S_UPD if FIFO still non-empty after the pop, else S_IDLE.
- Throughput: 1 resolution/cycle without mispredicts. A mispredict costs at least 2 cycles (S_UPD plus S_REDIR).
- Latency: resolution pushed at cycle N into an empty FIFO produces update pulses at N+1; a redirect becomes visible at N+2.
- Update pulses have no back-pressure; the BTB and predictor must accept them in the same cycle.
- flush_i:
  - Highest priority: empties FIFO, FSM to S_IDLE, deasserts redirect_valid_o and all pulses in the following cycle.
  - A push in the flush cycle is discarded.
  - GHR is preserved (it is committed history).
- A redirect accepted in the same cycle as flush_i is still considered delivered; the FIFO is empty afterwards.
- Full FIFO: bu_ready_o = 0; the branch unit holds its resolution.
- The FIFO is not written while the head is in S_REDIR only if it is full.

Optional Feature:
- Macro LEN5_BPU_STATS_EN.
- Enabled:
  - Adds ports stat_resolved_o [31:0] and stat_mispred_o [31:0].
  - stat_resolved_o increments on every S_UPD cycle; stat_mispred_o increments on S_UPD cycles with mispredict.
  - Both counters saturate at 2^32-1, reset to 0, and are unaffected by flush_i.
- Disabled: the ports and counters do not exist.

Decomposition:
- fetch_pkg: resolution_t (already present), plus new btb_upd_t {valid, del, pc, target} and bpu_upd_t {valid, pc, taken, ghr} structs, and res_handler_state_t enum.
- Sub-module res_fifo (parametric DATA_T, DEPTH, push/pop/full/empty/head) instantiated once; the FSM, GHR and redirect logic stay in the top.

Test Plan:
- Single correct taken resolution {pc=0x100, target=0x200, taken=1, mis=0} -> next cycle: btb write 0x100->0x200, bpu taken=1, GHR LSB=1, no redirect.
- Not-taken mispredict {pc=0x300, taken=0, mis=1} -> btb delete at 0x300, then redirect_pc_o=0x304 held with redirect_ready_i=0 for 3 cycles; pop only on ready.
- Back-to-back push of 5 resolutions with DEPTH=4 and redirect stalled -> bu_ready_o=0 after 4 entries; all 5 processed in order once the redirect is accepted.
- flush_i while in S_REDIR with 3 queued entries -> next cycle redirect_valid_o=0, FIFO empty, GHR unchanged.
- Eight alternating taken/not-taken correct resolutions, HLEN=8 -> ghr_o=8'b10101010 (first resolution taken); bpu_upd_ghr_o shows the pre-shift value each pulse.
- LEN5_BPU_STATS_EN: 10 resolutions, 3 mispredicted -> stat_resolved_o=10, stat_mispred_o=3.
